// File: rtl/port_inserter.sv
// Egress L4 port rewriter: overwrites source/destination ports from per-ID config
// and clears the UDP checksum of rewritten UDP packets. One registered output stage.
module port_inserter #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int MAX_PACKET_LENGTH = 1522,
  localparam int NUM_BUS_BYTES       = AXIS_BUS_WIDTH / 8,
  localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 1),
  localparam int EFF_ID_WIDTH        = (AXIS_ID_WIDTH > 1) ? AXIS_ID_WIDTH : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]        axis_in_tdata,
  input  logic [PACKET_LENGTH_CBITS+1:0]   axis_in_tuser,
  input  logic [EFF_ID_WIDTH-1:0]          axis_in_tid,
  input  logic [NUM_BUS_BYTES-1:0]         axis_in_tkeep,
  input  logic                             axis_in_tlast,
  input  logic                             axis_in_tvalid,
  output logic                             axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]        axis_out_tdata,
  output logic [PACKET_LENGTH_CBITS+1:0]   axis_out_tuser,
  output logic [EFF_ID_WIDTH-1:0]          axis_out_tid,
  output logic [NUM_BUS_BYTES-1:0]         axis_out_tkeep,
  output logic                             axis_out_tlast,
  output logic                             axis_out_tvalid,
  input  logic                             axis_out_tready,
  output logic [EFF_ID_WIDTH-1:0]          port_config_sel,
  input  logic [33:0]                      port_config_regs
);

  localparam int MAX_BEAT_INDEX = (MAX_PACKET_LENGTH + NUM_BUS_BYTES - 1) / NUM_BUS_BYTES;
  localparam int BEAT_CBITS     = $clog2(MAX_BEAT_INDEX + 1);
  localparam logic [BEAT_CBITS-1:0] BEAT_SAT = BEAT_CBITS'(MAX_BEAT_INDEX);

  logic                           in_packet;
  logic [BEAT_CBITS-1:0]          beat_idx;
  logic [33:0]                    cfg_q;
  logic                           is_udp_q;
  logic                           l4_valid_q;
  logic [PACKET_LENGTH_CBITS-1:0] l4_offset_q;

  logic                           accept;
  logic                           first_beat;
  logic [33:0]                    cur_cfg;
  logic                           cur_is_udp;
  logic                           cur_l4_valid;
  logic [PACKET_LENGTH_CBITS-1:0] cur_offset;
  logic [BEAT_CBITS-1:0]          cur_beat;
  logic [AXIS_BUS_WIDTH-1:0]      mod_data;

  assign port_config_sel = axis_in_tid;
  assign axis_in_tready  = !axis_out_tvalid || axis_out_tready;
  assign accept          = axis_in_tvalid && axis_in_tready;
  assign first_beat      = !in_packet;

  // The first beat of a packet works from the live config and tuser; later beats use the latched copy.
  assign cur_cfg      = first_beat ? port_config_regs : cfg_q;
  assign cur_is_udp   = first_beat ? axis_in_tuser[PACKET_LENGTH_CBITS+1] : is_udp_q;
  assign cur_l4_valid = first_beat ? axis_in_tuser[PACKET_LENGTH_CBITS] : l4_valid_q;
  assign cur_offset   = first_beat ? axis_in_tuser[PACKET_LENGTH_CBITS-1:0] : l4_offset_q;
  assign cur_beat     = first_beat ? '0 : beat_idx;

  always_comb begin
    int byte_idx;
    int off;
    logic force_src;
    logic force_dest;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    mod_data   = axis_in_tdata;
    byte_idx   = 0;
    off        = int'(cur_offset);
    force_dest = cur_cfg[33];
    dest_port  = cur_cfg[32:17];
    force_src  = cur_cfg[16];
    src_port   = cur_cfg[15:0];
    for (int k = 0; k < NUM_BUS_BYTES; k++) begin
      byte_idx = int'(cur_beat) * NUM_BUS_BYTES + k;
      // Lanes at the saturated beat index lie past any legal packet and are left alone.
      if (cur_l4_valid && axis_in_tkeep[k] && (cur_beat != BEAT_SAT)) begin
        if (force_src && byte_idx == off)
          mod_data[8*k +: 8] = src_port[15:8];
        else if (force_src && byte_idx == off + 1)
          mod_data[8*k +: 8] = src_port[7:0];
        else if (force_dest && byte_idx == off + 2)
          mod_data[8*k +: 8] = dest_port[15:8];
        else if (force_dest && byte_idx == off + 3)
          mod_data[8*k +: 8] = dest_port[7:0];
        else if (cur_is_udp && (force_src || force_dest) &&
                 (byte_idx == off + 6 || byte_idx == off + 7))
          mod_data[8*k +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axis_out_tdata  <= '0;
      axis_out_tuser  <= '0;
      axis_out_tid    <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      in_packet       <= 1'b0;
      beat_idx        <= '0;
      cfg_q           <= '0;
      is_udp_q        <= 1'b0;
      l4_valid_q      <= 1'b0;
      l4_offset_q     <= '0;
    end else begin
      if (accept) begin
        axis_out_tdata  <= mod_data;
        axis_out_tuser  <= axis_in_tuser;
        axis_out_tid    <= axis_in_tid;
        axis_out_tkeep  <= axis_in_tkeep;
        axis_out_tlast  <= axis_in_tlast;
        axis_out_tvalid <= 1'b1;
        if (first_beat) begin
          cfg_q       <= port_config_regs;
          is_udp_q    <= axis_in_tuser[PACKET_LENGTH_CBITS+1];
          l4_valid_q  <= axis_in_tuser[PACKET_LENGTH_CBITS];
          l4_offset_q <= axis_in_tuser[PACKET_LENGTH_CBITS-1:0];
        end
        in_packet <= !axis_in_tlast;
        if (axis_in_tlast)
          beat_idx <= '0;
        else if (cur_beat != BEAT_SAT)
          beat_idx <= cur_beat + 1'b1;
        else
          beat_idx <= cur_beat;
      end else if (axis_out_tready) begin
        axis_out_tvalid <= 1'b0;
      end
    end
  end

endmodule
